// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Multiplication uses shift-add over operand magnitudes. Division uses
// restoring radix-2 over operand magnitudes. Both run for n iterations.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
module muldiv_unit #(
  parameter int n  = 32,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [n-1:0]  req_a,
  input  logic [n-1:0]  req_b,
  input  logic [TW-1:0] req_tag,
  input  logic          flush,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [n-1:0]  resp_data,
  output logic [TW-1:0] resp_tag
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_q;
  logic           q_neg, r_neg;
  logic [n-1:0]   opnd;
  logic [2*n-1:0] prod;
  logic [5:0]     cnt;
  logic           last_q;

  logic           accept;
  logic           sign_a, sign_b, is_div, special;
  logic [n-1:0]   mag_a, mag_b, special_data;
  logic [n:0]     mul_sum, rem_sh, div_diff;
  logic [2*n-1:0] mul_nxt, div_nxt, full_prod;
  logic [n-1:0]   quo, rmd, result;

  assign accept = (state == IDLE) && req_valid && !flush;

  // Decode signedness, take operand magnitudes and detect the early-exit divide cases
  always_comb begin
    sign_a       = req_a[n-1] && (req_op != 3'd3) && (req_op != 3'd5) && (req_op != 3'd7);
    sign_b       = req_b[n-1] && (req_op == 3'd0 || req_op == 3'd1 || req_op == 3'd4 || req_op == 3'd6);
    mag_a        = sign_a ? -req_a : req_a;
    mag_b        = sign_b ? -req_b : req_b;
    is_div       = req_op[2];
    special      = 1'b0;
    special_data = '0;
    if (is_div && (req_b == '0)) begin
      special      = 1'b1;
      special_data = req_op[1] ? req_a : '1;
    end else if (is_div && !req_op[0] && (req_a == {1'b1, {(n-1){1'b0}}}) && (req_b == '1)) begin
      special      = 1'b1;
      special_data = req_op[1] ? '0 : req_a;
    end
  end

  // One shift-add multiply step and one restoring divide step on the shared product register
  always_comb begin
    mul_sum  = {1'b0, prod[2*n-1:n]} + (prod[0] ? {1'b0, opnd} : {(n+1){1'b0}});
    mul_nxt  = {mul_sum, prod[n-1:1]};
    rem_sh   = {prod[2*n-1:n], prod[n-1]};
    div_diff = rem_sh - {1'b0, opnd};
    if (!div_diff[n])
      div_nxt = {div_diff[n-1:0], prod[n-2:0], 1'b1};
    else
      div_nxt = {rem_sh[n-1:0], prod[n-2:0], 1'b0};
  end

  // Apply result signs and select the half of the product register that the op returns
  always_comb begin
    full_prod = q_neg ? -prod : prod;
    quo       = q_neg ? -prod[n-1:0] : prod[n-1:0];
    rmd       = r_neg ? -prod[2*n-1:n] : prod[2*n-1:n];
    case (op_q)
      3'd0:                result = full_prod[n-1:0];
      3'd1, 3'd2, 3'd3:    result = full_prod[2*n-1:n];
      3'd4, 3'd5:          result = quo;
      default:             result = rmd;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state_nxt = special ? DONE : CALC;
        CALC:    if (last_q) state_nxt = DONE;
        DONE:    if (resp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
  end

  // Datapath: latch the op at acceptance, iterate n times, then capture the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      opnd      <= '0;
      prod      <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else if (accept) begin
      op_q     <= req_op;
      resp_tag <= req_tag;
      q_neg    <= sign_a ^ sign_b;
      r_neg    <= sign_a;
      opnd     <= is_div ? mag_b : mag_a;
      prod     <= {{n{1'b0}}, (is_div ? mag_a : mag_b)};
      cnt      <= '0;
      last_q   <= 1'b0;
      if (special) resp_data <= special_data;
    end else if ((state == CALC) && !flush) begin
      if (!last_q) begin
        prod   <= op_q[2] ? div_nxt : mul_nxt;
        last_q <= (cnt == 6'(n-1));
        if (cnt != 6'(n-1)) cnt <= 6'(cnt + 6'd1);
      end else begin
        resp_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a behavioural
// reference model built on native 64-bit signed/unsigned arithmetic.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_tag;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_tag;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  tag;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.n(32), .TW(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sbv;
    logic [31:0]        r;
    sa  = a;
    sbv = b;
    r   = '0;
    case (op)
      3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = sa / sbv;
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = sa % sbv;
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int modelLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, push its expected response, then scramble the request bus
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    e.data = modelResult(op, a, b);
    e.tag  = tag;
    e.lat  = modelLatency(op, a, b);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_tag   = 2'($urandom);
  endtask

  // Wait for the response, compare against the scoreboard, hold it, then release
  task automatic collectResponse(input int hold, input bit poke);
    int   cycles = 0;
    exp_t e;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!resp_valid && cycles < 100);
    checkOutput("resp_valid_seen", 64'(resp_valid), 64'd1);
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    checkOutput("latency", 64'(cycles), 64'(e.lat));
    checkOutput("resp_data", 64'(resp_data), 64'(e.data));
    checkOutput("resp_tag", 64'(resp_tag), 64'(e.tag));
    checkOutput("req_ready_in_done", 64'(req_ready), 64'd0);
    if (!resp_valid) return;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
      end
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 64'(resp_valid), 64'd1);
      checkOutput("hold_data", 64'(resp_data), 64'(e.data));
      checkOutput("hold_tag", 64'(resp_tag), 64'(e.tag));
      checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("release_valid", 64'(resp_valid), 64'd0);
    checkOutput("release_req_ready", 64'(req_ready), 64'd1);
  endtask

  // Count any response that appears over a quiet window
  task automatic expectSilence(input string name, input int window);
    int seen = 0;
    for (int i = 0; i < window; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checkOutput(name, 64'(seen), 64'd0);
  endtask

  logic [2:0]  v_op  [11] = '{3'd3, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd4, 3'd6, 3'd1, 3'd5, 3'd6};
  logic [31:0] v_a   [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
  logic [31:0] v_b   [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd0};

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    #12;
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_resp_data", 64'(resp_data), 64'd0);
    checkOutput("reset_resp_tag", 64'(resp_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);

    // mul 7 * -3 with a long hold and spurious requests while busy
    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 2'd2);
    collectResponse(5, 1'b1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(v_op[i], v_a[i], v_b[i], 2'(i));
      collectResponse(i % 3, 1'b0);
    end

    // flush in the middle of an iteration
    applyStimulus(3'd0, 32'd123, 32'd456, 2'd1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("flush_req_ready", 64'(req_ready), 64'd1);
    void'(sbq.pop_back());
    expectSilence("no_resp_after_flush", 40);
    applyStimulus(3'd6, 32'd100, 32'd7, 2'd2);
    collectResponse(1, 1'b0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd1;
    req_b     = 32'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("idle_flush_blocks_accept", 64'(req_ready), 64'd1);
    expectSilence("no_resp_after_idle_flush", 40);

    // asynchronous reset in the middle of an iteration
    applyStimulus(3'd1, 32'd5, 32'd9, 2'd3);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midreset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("midreset_resp_data", 64'(resp_data), 64'd0);
    checkOutput("midreset_resp_tag", 64'(resp_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    void'(sbq.pop_back());
    expectSilence("no_resp_after_reset", 40);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 2'd1);
    collectResponse(0, 1'b0);

    // random operations, with some zero divisors
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus(rop, ra, rb, 2'($urandom));
      collectResponse(i % 3, i[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: n, default 32, operand/result width.
REQ-002 Parameter: TW, default 2, thread-tag width (one tag per hardware thread).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  1  issue stage presents an M-extension op.
REQ-006 Port: req_ready  output  1  unit accepts an op this cycle.
REQ-007 Port: req_op  input  3  RISC-V funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-008 Port: req_a, req_b  input  n each  rs1 and rs2 operands.
REQ-009 Port: req_tag  input  TW  issuing thread ID.
REQ-010 Port: flush  input  1  abort any in-flight op; no response is produced for it.
REQ-011 Port: resp_valid  output  1  result available.
REQ-012 Port: resp_ready  input  1  writeback consumes the result.
REQ-013 Port: resp_data  output  n  result.
REQ-014 Port: resp_tag  output  TW  tag of the accepted op.

Function
REQ-015 FSM states IDLE, CALC, DONE; req_ready = 1 only in IDLE, resp_valid = 1 only in DONE.
REQ-016 Accept on the edge where req_valid && req_ready; latch op, tag, operand magnitudes, and result-sign flags.
REQ-017 Normal ops: IDLE -> CALC, exactly n iterations (6-bit counter 0..n-1), then CALC -> DONE; resp_valid first high n+1 cycles after the accept edge.
REQ-018 Multiply: unsigned shift-add over magnitudes into a 2n-bit product; negate if the result sign is negative; mul returns low n bits, mulh/mulhsu/mulhu return high n bits.
REQ-019 Signedness: mul/mulh/div/rem treat both operands as signed; mulhsu treats a as signed, b as unsigned; mulhu/divu/remu treat both as unsigned.
REQ-020 Divide: restoring radix-2 over magnitudes, one quotient bit per cycle; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Divide by zero (b == 0, ops 4-7): IDLE -> DONE directly (resp_valid 1 cycle after accept); div/divu = all ones, rem/remu = a.
REQ-022 Signed overflow (a = -2^(n-1), b = -1, ops 4/6): IDLE -> DONE directly; div = -2^(n-1), rem = 0.
REQ-023 DONE holds resp_data/resp_tag stable until resp_valid && resp_ready; then DONE -> IDLE; no new request is accepted in that same cycle.
REQ-024 flush in CALC or DONE -> IDLE next edge, resp_valid low from that edge; flush in IDLE blocks acceptance that cycle; flush has priority over all other transitions.
REQ-025 req_valid asserted while not in IDLE has no effect on internal state.
REQ-026 Operands are sampled only at acceptance; changes to req_a/req_b/req_op afterwards do not affect the result.

Reset
REQ-027 reset asserted: immediately (asynchronously) state = IDLE, counter = 0, resp_valid = 0, resp_data = 0, resp_tag = 0; req_ready = 1 after reset deasserts.
REQ-028 reset mid-CALC or in DONE discards the op; no response follows.

Verification
REQ-029 mul a=7, b=-3, tag 2 -> resp_valid 33 cycles after accept, resp_data = 0xFFFFFFEB, resp_tag = 2.
REQ-030 mulhu a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 div a=-7, b=2 -> 0xFFFFFFFD; rem a=-7, b=2 -> 0xFFFFFFFF; remu a=7, b=2 -> 1.
REQ-032 divu a=5, b=0 -> 0xFFFFFFFF in 1 cycle; div a=0x80000000, b=-1 -> 0x80000000, rem -> 0.
REQ-033 Hold resp_ready = 0 for 5 cycles in DONE -> resp_data stable, req_ready = 0 throughout; one-cycle resp_ready -> IDLE next edge.
REQ-034 flush at CALC cycle 10 -> no resp_valid; next accepted op gives a correct result; reset at CALC cycle 5 -> outputs 0 immediately.
